rf_ctrl: RTL and testbench
==========================

# rf_ctrl

Register-file access controller: the initiator that drives the RF write/read port set (`write`, `addr1..3`, `data1..3`). It accepts one register-to-register operation at a time over a valid/ready request channel, performs the two-port read, computes the result, and commits the write. It returns the result on a valid/ready response channel. It sits between instruction decode and the 4×16-bit `RF`. This RF has combinational reads and commits a write on the rising `clk` edge when `write`=1.

## Interface
- `WORD_SIZE`, 16, data width
- `NUM_REG`, 4, number of registers; `ADDR_W` = $clog2(NUM_REG) = 2 (derived)

- `clk`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller can accept (IDLE only)
- `req_op`  in  2  00 ADD, 01 SUB, 10 ADDI, 11 RD
- `req_rs`, `req_rt`, `req_rd`  in  ADDR_W each  source/source/destination register
- `req_imm`  in  WORD_SIZE  immediate (ADDI only)
- `rsp_valid`  out  1  result available
- `rsp_ready`  in  1  consumer accepts result
- `rsp_data`  out  WORD_SIZE  result (written value, or rs value for RD)
- `rf_write`  out  1  to RF `write`
- `rf_addr1`, `rf_addr2`, `rf_addr3`  out  ADDR_W each  to RF `addr1/2/3`
- `rf_wdata`  out  WORD_SIZE  to RF `data3`
- `rf_data1`, `rf_data2`  in  WORD_SIZE  from RF `data1/2`

## Operation
- FSM states: IDLE, READ, EXEC, WRITE, DONE.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, latch op/rs/rt/rd/imm, load `rf_addr1`=rs and `rf_addr2`=rt, then go to READ.
- READ: RF outputs settle. At the end edge, capture `rf_data1`/`rf_data2` into operand registers, then go to EXEC.
- EXEC: compute the result.
  - ADD: a+b mod 2^16.
  - SUB: a−b mod 2^16.
  - ADDI: a+imm mod 2^16.
  - RD: a.
  - No carry/overflow output.
- EXEC end edge: latch `rsp_data`=result.
  - ADD/SUB/ADDI: load `rf_addr3`=rd, `rf_wdata`=result, `rf_write`=1, then go to WRITE.
  - RD: go to DONE; `rf_write` stays 0.
- WRITE: the RF commits at the end edge. At that edge `rf_write`←0, then go to DONE.
- DONE: `rsp_valid`=1. `rsp_data` is stable until `rsp_valid`&&`rsp_ready`, then go to IDLE.
- `req_valid` is ignored outside IDLE.
- All outputs are registered.
- Reset values: `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rf_write`=0, all `rf_addr*`=0, `rf_wdata`=0, state IDLE.
- rd may equal rs/rt. Operands are captured before the write, so the old values are used.

## Timing
- E0 is the accept edge.
  - READ occupies E0–E1.
  - EXEC occupies E1–E2.
  - WRITE occupies E2–E3; the RF register is updated at E3.
  - `rsp_valid` rises after E3 for ADD/SUB/ADDI, or after E2 for RD.
- Earliest next accept is the edge after the response handshake. `req_ready`=1 one cycle after that handshake edge.
- Back-to-back requests: the next READ starts at least 2 edges after the write-commit edge, so a dependent read sees the new value. No forwarding.
- `rf_write` is high for exactly one cycle per writing op and never for RD.
- Reset mid-operation: `reset_n`=0 immediately forces all outputs to their reset values, including `rf_write`=0. An in-flight write whose commit edge has not occurred is dropped. The operation is lost and no response is produced.
- `rsp_ready` held low: the controller stalls in DONE indefinitely, with outputs frozen.

## Structure
- Shared package `rf_pkg`: `WORD_SIZE`, `NUM_REG`, op encodings (OP_ADD/SUB/ADDI/RD), FSM state encoding. The RF and its bench import the same constants.
- One combinational sub-module, `rf_ctrl_alu`: inputs op, a, b, imm; output result. The FSM, operand registers and output registers live in `rf_ctrl`.

## Test plan
Bench instantiates `rf_ctrl` + `RF`, with `RF` `reset` = ~`reset_n`.
1. Reset: hold `reset_n`=0 for 2 cycles, release. Check `req_ready`=1, `rsp_valid`=0, `rf_write`=0, all addresses/data 0, and all RF registers 0.
2. ADDI rd=1, rs=0, imm=0x52df → `rsp_valid` after E3, `rsp_data`=0x52df. RF r1=0x52df. `rf_write` high exactly one cycle, with `rf_addr3`=1.
3. ADD rd=2, rs=1, rt=1 → 0xa5be. Then SUB rd=3, rs=0, rt=1 → 0xad21 (wrap). Then ADD rd=1, rs=1, rt=2 → 0xf89d (dependent back-to-back; old-value read of rd).
4. RD rs=3 → `rsp_data`=0xad21 after E2. `rf_write` never asserted; all RF registers unchanged.
5. Backpressure: `rsp_ready`=0 for 3 cycles while `req_valid`=1. `rsp_valid`/`rsp_data` stay stable, `req_ready`=0, and no new request is accepted until the handshake.
6. Reset during WRITE: drop `reset_n` mid-cycle before E3 of ADDI rd=2, imm=0x1234. `rf_write` falls immediately, `rsp_valid` never rises, and FSM returns to IDLE.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared constants for the register file and its access controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: data/register sizing, operation encodings, controller FSM state encoding.
package rf_pkg;

    localparam int WORD_SIZE = 16;
    localparam int NUM_REG   = 4;
    localparam int ADDR_W    = $clog2(NUM_REG);

    // Request operation encodings
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_ADDI = 2'b10;
    localparam logic [1:0] OP_RD   = 2'b11;

    // Controller FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/rf_ctrl_alu.sv
// Result datapath for the register-file controller: ADD/SUB/ADDI/RD.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers the result when it needs it.
// Ports: op (operation), a/b (rs/rt operands), imm (immediate), result (mod 2^WORD_SIZE).
module rf_ctrl_alu
    import rf_pkg::*;
(
    input  logic [1:0]           op,
    input  logic [WORD_SIZE-1:0] a,
    input  logic [WORD_SIZE-1:0] b,
    input  logic [WORD_SIZE-1:0] imm,
    output logic [WORD_SIZE-1:0] result
);

    // Carries and borrows are discarded: results wrap modulo 2^WORD_SIZE.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_ADDI: result = a + imm;
            OP_RD:   result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/rf_ctrl.sv
// Register-file access controller: one read-compute-write operation at a time.
// Latency: accept edge E0, write commits at E3 (rsp_valid after E3); RD responds after E2.
// Backpressure: req_ready only in IDLE; holds the response in DONE until rsp_ready.
// Ports: clk/reset_n; req_* request channel (op, rs, rt, rd, imm); rsp_* response channel;
//        rf_write/rf_addr1..3/rf_wdata drive the RF port set; rf_data1/2 are its read data.
module rf_ctrl
    import rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [ADDR_W-1:0]    req_rs,
    input  logic [ADDR_W-1:0]    req_rt,
    input  logic [ADDR_W-1:0]    req_rd,
    input  logic [WORD_SIZE-1:0] req_imm,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_data,
    output logic                 rf_write,
    output logic [ADDR_W-1:0]    rf_addr1,
    output logic [ADDR_W-1:0]    rf_addr2,
    output logic [ADDR_W-1:0]    rf_addr3,
    output logic [WORD_SIZE-1:0] rf_wdata,
    input  logic [WORD_SIZE-1:0] rf_data1,
    input  logic [WORD_SIZE-1:0] rf_data2
);

    logic [2:0]           state;
    logic [1:0]           op_q;
    logic [ADDR_W-1:0]    rd_q;
    logic [WORD_SIZE-1:0] imm_q;
    logic [WORD_SIZE-1:0] opa_q;
    logic [WORD_SIZE-1:0] opb_q;
    logic [WORD_SIZE-1:0] alu_result;

    rf_ctrl_alu u_alu (
        .op     (op_q),
        .a      (opa_q),
        .b      (opb_q),
        .imm    (imm_q),
        .result (alu_result)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rf_write  <= 1'b0;
            rf_addr1  <= '0;
            rf_addr2  <= '0;
            rf_addr3  <= '0;
            rf_wdata  <= '0;
            op_q      <= OP_ADD;
            rd_q      <= '0;
            imm_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // req_ready is registered high only in IDLE, so it gates the accept.
                    if (req_valid && req_ready) begin
                        op_q      <= req_op;
                        rd_q      <= req_rd;
                        imm_q     <= req_imm;
                        rf_addr1  <= req_rs;
                        rf_addr2  <= req_rt;
                        req_ready <= 1'b0;
                        state     <= ST_READ;
                    end
                end
                ST_READ: begin
                    // Operands are captured before any write, so rd==rs/rt uses old values.
                    opa_q <= rf_data1;
                    opb_q <= rf_data2;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    rsp_data <= alu_result;
                    if (op_q == OP_RD) begin
                        rsp_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        rf_addr3 <= rd_q;
                        rf_wdata <= alu_result;
                        rf_write <= 1'b1;
                        state    <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // The RF commits on this edge; the response becomes visible after it.
                    rf_write  <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (rsp_valid && rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rf_write  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_ctrl.sv
module tb_rf_ctrl;
    import rf_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 req_valid;
    logic                 req_ready;
    logic [1:0]           req_op;
    logic [ADDR_W-1:0]    req_rs;
    logic [ADDR_W-1:0]    req_rt;
    logic [ADDR_W-1:0]    req_rd;
    logic [WORD_SIZE-1:0] req_imm;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [WORD_SIZE-1:0] rsp_data;
    logic                 rf_write;
    logic [ADDR_W-1:0]    rf_addr1;
    logic [ADDR_W-1:0]    rf_addr2;
    logic [ADDR_W-1:0]    rf_addr3;
    logic [WORD_SIZE-1:0] rf_wdata;
    logic [WORD_SIZE-1:0] rf_data1;
    logic [WORD_SIZE-1:0] rf_data2;

    int check_cnt = 0;
    int pass_cnt  = 0;

    always #5 clk = ~clk;

    rf_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_rs    (req_rs),
        .req_rt    (req_rt),
        .req_rd    (req_rd),
        .req_imm   (req_imm),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rf_write  (rf_write),
        .rf_addr1  (rf_addr1),
        .rf_addr2  (rf_addr2),
        .rf_addr3  (rf_addr3),
        .rf_wdata  (rf_wdata),
        .rf_data1  (rf_data1),
        .rf_data2  (rf_data2)
    );

    // Register file: combinational reads, write on rising edge, reset = ~reset_n sampled on the edge.
    logic [WORD_SIZE-1:0] rf_mem [NUM_REG];
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REG; i++) rf_mem[i] <= '0;
        end else if (rf_write) begin
            rf_mem[rf_addr3] <= rf_wdata;
        end
    end
    assign rf_data1 = rf_mem[rf_addr1];
    assign rf_data2 = rf_mem[rf_addr2];

    // Reference model: expected register contents and operation semantics.
    logic [WORD_SIZE-1:0] ref_rf [NUM_REG];

    function automatic logic [WORD_SIZE-1:0] ref_result(input logic [1:0] op,
                                                        input logic [WORD_SIZE-1:0] a,
                                                        input logic [WORD_SIZE-1:0] b,
                                                        input logic [WORD_SIZE-1:0] imm);
        logic [31:0] full;
        case (op)
            OP_ADD:  full = {16'h0, a} + {16'h0, b};
            OP_SUB:  full = {16'h0, a} - {16'h0, b};
            OP_ADDI: full = {16'h0, a} + {16'h0, imm};
            default: full = {16'h0, a};
        endcase
        return full[WORD_SIZE-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation end to end and checks latency, write pulse, response and RF state.
    task automatic run_op(input logic [1:0] op, input logic [ADDR_W-1:0] rs,
                          input logic [ADDR_W-1:0] rt, input logic [ADDR_W-1:0] rd,
                          input logic [WORD_SIZE-1:0] imm, input logic [WORD_SIZE-1:0] exp,
                          input int stall, input bit hold_valid);
        int n;
        int lat;
        int wr_cnt;
        int exp_lat;
        int exp_wr;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_cnt++;
        if (req_ready !== 1'b1) $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
        else pass_cnt++;

        req_valid = 1'b1; req_op = op; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm;
        tick(); // accept edge E0
        if (hold_valid) begin
            // A different request stays presented; it must be ignored until IDLE.
            req_op = OP_ADD; req_rd = rd + 2'd1; req_imm = ~imm;
        end else begin
            req_valid = 1'b0;
        end

        lat = 0;
        wr_cnt = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            if (rf_write === 1'b1) begin
                wr_cnt++;
                check_cnt++;
                if (rf_addr3 !== rd || rf_wdata !== exp)
                    $display("FAIL write_port: addr3=%0d wdata=%h required addr3=%0d wdata=%h",
                             rf_addr3, rf_wdata, rd, exp);
                else pass_cnt++;
            end
            tick();
            lat++;
        end
        exp_lat = (op == OP_RD) ? 2 : 3;
        exp_wr  = (op == OP_RD) ? 0 : 1;
        check_cnt++;
        if (lat != exp_lat) $display("FAIL latency: op=%0d edges=%0d required %0d", op, lat, exp_lat);
        else pass_cnt++;
        check_cnt++;
        if (wr_cnt != exp_wr) $display("FAIL write_pulses: op=%0d count=%0d required %0d", op, wr_cnt, exp_wr);
        else pass_cnt++;
        check_cnt++;
        if (rsp_data !== exp) $display("FAIL rsp_data: op=%0d got %h required %h", op, rsp_data, exp);
        else pass_cnt++;

        for (int s = 0; s < stall; s++) begin
            tick();
            check_cnt++;
            if ({rsp_valid, rsp_data, req_ready, rf_write} !== {1'b1, exp, 1'b0, 1'b0})
                $display("FAIL stall_hold: valid=%b data=%h ready=%b write=%b required 1 %h 0 0",
                         rsp_valid, rsp_data, req_ready, rf_write, exp);
            else pass_cnt++;
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick(); // handshake edge
        rsp_ready = 1'b0;
        check_cnt++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL handshake: rsp_valid=%b req_ready=%b required 0 1", rsp_valid, req_ready);
        else pass_cnt++;

        if (op != OP_RD) ref_rf[rd] = ref_result(op, ref_rf[rs], ref_rf[rt], imm);
        for (int r = 0; r < NUM_REG; r++) begin
            check_cnt++;
            if (rf_mem[r] !== ref_rf[r]) $display("FAIL rf_reg%0d: got %h required %h", r, rf_mem[r], ref_rf[r]);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_op = OP_ADD; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
        for (int r = 0; r < NUM_REG; r++) ref_rf[r] = '0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        check_cnt++;
        if ({req_ready, rsp_valid, rf_write} !== 3'b100)
            $display("FAIL reset_ctrl: ready/valid/write=%b required 100", {req_ready, rsp_valid, rf_write});
        else pass_cnt++;
        check_cnt++;
        if ({rf_addr1, rf_addr2, rf_addr3, rf_wdata, rsp_data} !== '0)
            $display("FAIL reset_data: a1=%0d a2=%0d a3=%0d wdata=%h rsp=%h required all 0",
                     rf_addr1, rf_addr2, rf_addr3, rf_wdata, rsp_data);
        else pass_cnt++;
        for (int r = 0; r < NUM_REG; r++) begin
            check_cnt++;
            if (rf_mem[r] !== '0) $display("FAIL reset_reg%0d: got %h required 0", r, rf_mem[r]);
            else pass_cnt++;
        end
    endtask

    task automatic test_addi();
        run_op(OP_ADDI, 2'd0, 2'd0, 2'd1, 16'h52df, 16'h52df, 0, 1'b0);
    endtask

    task automatic test_arith_chain();
        run_op(OP_ADD, 2'd1, 2'd1, 2'd2, 16'h0000, 16'ha5be, 0, 1'b0);
        run_op(OP_SUB, 2'd0, 2'd1, 2'd3, 16'h0000, 16'had21, 0, 1'b0);
        run_op(OP_ADD, 2'd1, 2'd2, 2'd1, 16'h0000, 16'hf89d, 0, 1'b0);
    endtask

    task automatic test_rd();
        run_op(OP_RD, 2'd3, 2'd0, 2'd0, 16'hffff, 16'had21, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op(OP_ADD, 2'd2, 2'd3, 2'd0, 16'h0000, 16'h52df, 3, 1'b1);
    endtask

    task automatic test_reset_write();
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        req_valid = 1'b1; req_op = OP_ADDI; req_rs = 2'd0; req_rt = 2'd0; req_rd = 2'd2; req_imm = 16'h1234;
        tick(); // E0
        req_valid = 1'b0;
        tick(); // E1
        tick(); // E2, now in WRITE
        check_cnt++;
        if (rf_write !== 1'b1) $display("FAIL mid_write_pulse: rf_write=%b required 1", rf_write);
        else pass_cnt++;
        #2;
        reset_n = 1'b0;
        #1;
        check_cnt++;
        if ({rf_write, rsp_valid, req_ready, rf_addr3, rf_wdata, rsp_data} !== {3'b001, 2'd0, 32'h0})
            $display("FAIL async_reset: write=%b valid=%b ready=%b a3=%0d wdata=%h rsp=%h required 0 0 1 0 0 0",
                     rf_write, rsp_valid, req_ready, rf_addr3, rf_wdata, rsp_data);
        else pass_cnt++;
        #2;
        reset_n = 1'b1;
        tick(); // E3: the dropped write must not commit
        check_cnt++;
        if (rf_mem[2] !== ref_rf[2]) $display("FAIL dropped_write: r2=%h required %h", rf_mem[2], ref_rf[2]);
        else pass_cnt++;
        for (int c = 0; c < 6; c++) begin
            check_cnt++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rf_write !== 1'b0)
                $display("FAIL post_reset_idle: valid=%b ready=%b write=%b required 0 1 0",
                         rsp_valid, req_ready, rf_write);
            else pass_cnt++;
            tick();
        end
        // Controller must still work after the aborted operation.
        run_op(OP_RD, 2'd2, 2'd0, 2'd0, 16'h0000, ref_rf[2], 0, 1'b0);
    endtask

    task automatic test_random();
        logic [1:0]           op;
        logic [ADDR_W-1:0]    rs;
        logic [ADDR_W-1:0]    rt;
        logic [ADDR_W-1:0]    rd;
        logic [WORD_SIZE-1:0] imm;
        for (int k = 0; k < 24; k++) begin
            op  = 2'($urandom_range(0, 3));
            rs  = 2'($urandom_range(0, 3));
            rt  = 2'($urandom_range(0, 3));
            rd  = 2'($urandom_range(0, 3));
            imm = 16'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
            run_op(op, rs, rt, rd, imm, ref_result(op, ref_rf[rs], ref_rf[rt], imm),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_arith_chain();
        test_rd();
        test_backpressure();
        test_reset_write();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
